// File: rtl/game_pkg.sv
// Shared state encoding and default timing constants for the game round controller.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_COUNTDOWN = 2'b01,
        ST_PLAY      = 2'b10,
        ST_OVER      = 2'b11
    } game_state_e;

    localparam int unsigned DEF_MONSTERS    = 12;
    localparam int unsigned DEF_BASE_PERIOD = 25_000_000;
    localparam int unsigned DEF_STEP_PERIOD = 2_500_000;
    localparam int unsigned DEF_MIN_PERIOD  = 5_000_000;
    localparam int unsigned DEF_COUNTDOWN   = 50_000_000;
    localparam int unsigned DEF_LEVEL_STEP  = 10;
    localparam int unsigned DEF_MAX_LEVEL   = 7;
    localparam int unsigned DEF_SCORE_W     = 14;

endpackage

// File: rtl/move_prescaler.sv
// Free-running cycle counter that wraps at period-1 and flags the wrap cycle.
module move_prescaler #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             tick_o_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // >= rather than == so a shrinking period still wraps on the next cycle
    assign tick_o_c = en_i && (cnt_q >= (period_i - CNT_W'(1)));

    // Next count: clear wins, otherwise count and wrap on tick
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Round controller: IDLE/COUNTDOWN/PLAY/OVER sequencing, move tick, spawn gating, scoring.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned MONSTERS    = DEF_MONSTERS,
    parameter int unsigned BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int unsigned STEP_PERIOD = DEF_STEP_PERIOD,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int unsigned COUNTDOWN   = DEF_COUNTDOWN,
    parameter int unsigned LEVEL_STEP  = DEF_LEVEL_STEP,
    parameter int unsigned MAX_LEVEL   = DEF_MAX_LEVEL,
    parameter int unsigned SCORE_W     = DEF_SCORE_W
) (
    input  logic                clk_game,
    input  logic                rst,
    input  logic                start,
    input  logic                alive,
    input  logic [MONSTERS-1:0] score_pulse,
    output logic                game_start,
    output logic                move_tick,
    output logic [MONSTERS-1:0] spawn_mask,
    output logic [1:0]          state,
    output logic [2:0]          level,
    output logic [SCORE_W-1:0]  score,
    output logic [SCORE_W-1:0]  hi_score
);

    localparam int unsigned CNT_MAX   = (BASE_PERIOD > COUNTDOWN) ? BASE_PERIOD : COUNTDOWN;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned PC_W      = $clog2(MONSTERS + 1);
    localparam int unsigned SUM_W     = SCORE_W + PC_W;
    localparam int unsigned THR_W     = SCORE_W + 1;
    localparam int unsigned SCORE_MAX = (1 << SCORE_W) - 1;
    localparam int unsigned DROP_MAX  = (BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD - MIN_PERIOD : 0;

    function automatic logic [PC_W-1:0] popcount(input logic [MONSTERS-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < MONSTERS; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // Low min(MONSTERS, 2+2*level) slots enabled
    function automatic logic [MONSTERS-1:0] mask_for(input logic [2:0] lvl);
        logic [MONSTERS-1:0] m;
        int unsigned         n;
        n = 32'd2 + 32'd2 * 32'(lvl);
        for (int i = 0; i < MONSTERS; i++) begin
            m[i] = (32'(i) < n);
        end
        return m;
    endfunction

    game_state_e         state_q, state_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [SCORE_W-1:0]  hi_q, hi_d;
    logic [2:0]          level_q, level_d;
    logic [THR_W-1:0]    thr_q, thr_d;
    logic                game_start_q, game_start_d;
    logic                move_tick_q, move_tick_d;
    logic [MONSTERS-1:0] spawn_mask_q, spawn_mask_d;
    logic                start_q, alive_q;
    logic [MONSTERS-1:0] pulse_q;

    logic                start_ev;
    logic                alive_fall;
    logic [PC_W-1:0]     kills;
    logic [SUM_W-1:0]    score_sum;
    logic [SCORE_W-1:0]  score_sat;
    logic [31:0]         drop;
    logic [CNT_W-1:0]    move_period;
    logic [CNT_W-1:0]    presc_period;
    logic                presc_en;
    logic                presc_clr;
    logic                presc_tick;
    logic                clear_game;

    assign start_ev   = start & ~start_q;
    assign alive_fall = alive_q & ~alive;
    assign kills      = popcount(score_pulse & ~pulse_q);
    assign score_sum  = SUM_W'(score_q) + SUM_W'(kills);
    assign score_sat  = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                         : score_sum[SCORE_W-1:0];

    // Level-dependent move period with a floor
    always_comb begin
        drop        = 32'(level_q) * STEP_PERIOD;
        move_period = (drop >= DROP_MAX) ? CNT_W'(MIN_PERIOD) : CNT_W'(BASE_PERIOD - drop);
    end

    // One counter serves both the countdown timer and the move prescaler
    assign presc_en     = (state_q == ST_COUNTDOWN) || (state_q == ST_PLAY);
    assign presc_period = (state_q == ST_COUNTDOWN) ? CNT_W'(COUNTDOWN) : move_period;

    move_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk_i    (clk_game),
        .rst_i    (rst),
        .en_i     (presc_en),
        .clr_i    (presc_clr),
        .period_i (presc_period),
        .tick_o_c (presc_tick)
    );

    // Next-state, scoring and level tracking
    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        hi_d         = hi_q;
        level_d      = level_q;
        thr_d        = thr_q;
        game_start_d = 1'b0;
        move_tick_d  = 1'b0;
        presc_clr    = 1'b0;
        clear_game   = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_ev) begin
                    state_d    = ST_COUNTDOWN;
                    presc_clr  = 1'b1;
                    clear_game = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                if (presc_tick) begin
                    state_d      = ST_PLAY;
                    game_start_d = 1'b1;
                end
            end
            ST_PLAY: begin
                score_d = score_sat;
                if (alive_fall) begin
                    state_d = ST_OVER;
                    if (score_sat > hi_q) begin
                        hi_d = score_sat;
                    end
                end else if (start_ev) begin
                    state_d    = ST_IDLE;
                    clear_game = 1'b1;
                end else begin
                    move_tick_d = presc_tick;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Level follows score one step per cycle via a running threshold
        if (clear_game) begin
            score_d = '0;
            level_d = '0;
            thr_d   = THR_W'(LEVEL_STEP);
        end else if ((level_q < 3'(MAX_LEVEL)) && (THR_W'(score_q) >= thr_q)) begin
            level_d = level_q + 3'd1;
            thr_d   = thr_q + THR_W'(LEVEL_STEP);
        end

        spawn_mask_d = (state_d == ST_PLAY) ? mask_for(level_d) : '0;
    end

    // State, score and output registers
    always_ff @(posedge clk_game) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            score_q      <= '0;
            hi_q         <= '0;
            level_q      <= '0;
            thr_q        <= THR_W'(LEVEL_STEP);
            game_start_q <= 1'b0;
            move_tick_q  <= 1'b0;
            spawn_mask_q <= '0;
            start_q      <= 1'b0;
            alive_q      <= 1'b0;
            pulse_q      <= '0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            hi_q         <= hi_d;
            level_q      <= level_d;
            thr_q        <= thr_d;
            game_start_q <= game_start_d;
            move_tick_q  <= move_tick_d;
            spawn_mask_q <= spawn_mask_d;
            start_q      <= start;
            alive_q      <= alive;
            pulse_q      <= score_pulse;
        end
    end

    assign game_start = game_start_q;
    assign move_tick  = move_tick_q;
    assign spawn_mask = spawn_mask_q;
    assign state      = state_q;
    assign level      = level_q;
    assign score      = score_q;
    assign hi_score   = hi_q;

endmodule
